// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// wrong-path squash, mul/div hold and data-memory wait states.
module pipe_stall_ctrl #(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RD_E,
  input  logic        MemReadE,
  input  logic        PCSrcE,
  input  logic        MduOpE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic        MduStart,
  output logic        Busy,
  output logic [31:0] StallCnt
);

  localparam int unsigned SC_W = 32;

  typedef enum logic {RUN, MDU} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               memwait, lwstall;

  assign memwait = MemReqM & ~MemReadyM;
  assign lwstall = MemReadE & (RD_E != 5'd0) & ((RD_E == RS1_D) | (RD_E == RS2_D));

  // Priority decode: memory wait > mul/div hold > mul/div entry > squash > load-use
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    MduStart = 1'b0;
    if (rst) begin
      if (memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (state_q == MDU) begin
        if (cnt_q != '0) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end else if (MduOpE) begin
        MduStart = 1'b1;
        StallF   = 1'b1;
        StallD   = 1'b1;
        StallE   = 1'b1;
        FlushM   = 1'b1;
        state_d  = MDU;
        cnt_d    = CNT_W'(MDU_LAT - 1);
      end else if (PCSrcE) begin
        // Decode holds a wrong-path instruction, so any load-use match is moot
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      StallCnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (StallF) StallCnt <= StallCnt + SC_W'(1);
    end
  end

  assign Busy = rst & (state_q == MDU);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MDU_LAT=4; expected control
// vectors are hand-derived per cycle.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RS1_D, RS2_D, RD_E;
  logic        MemReadE, PCSrcE, MduOpE, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushM, FlushW;
  logic        MduStart, Busy;
  logic [31:0] StallCnt;

  int total = 0;
  int bad   = 0;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MduStart}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LW   = 9'b110001000;
  localparam logic [8:0] C_BR   = 9'b000011000;
  localparam logic [8:0] C_MDUE = 9'b111000101;
  localparam logic [8:0] C_MDUS = 9'b111000100;
  localparam logic [8:0] C_MW   = 9'b111100010;

  logic [8:0] ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MduStart};

  pipe_stall_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_E(RD_E),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MduOpE(MduOpE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MduStart(MduStart), .Busy(Busy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mr, input logic pc, input logic mdu,
                        input logic mreq, input logic mrdy);
    RS1_D = rs1; RS2_D = rs2; RD_E = rd;
    MemReadE = mr; PCSrcE = pc; MduOpE = mdu;
    MemReqM = mreq; MemReadyM = mrdy;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle (inputs already applied) then advance one clock
  task automatic cyc(input string tag, input logic [8:0] ectl, input logic ebusy,
                     input logic [31:0] esc);
    #1;
    chk({tag, "_ctl"}, 32'(ctl), 32'(ectl));
    chk({tag, "_busy"}, 32'(Busy), 32'(ebusy));
    chk({tag, "_cnt"}, StallCnt, esc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a live load-use condition: outputs must stay forced low
    rst = 1'b0;
    set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_busy", 32'(Busy), 32'd0);
    @(posedge clk); #1;
    chk("rst_cnt", StallCnt, 32'd0);

    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle", C_NONE, 1'b0, 32'd0);

    // Load-use on RS1: exactly one bubble
    set_in(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lw_rs1", C_LW, 1'b0, 32'd0);
    set_in(5'd5, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lw_after", C_NONE, 1'b0, 32'd1);

    // x0 destination never stalls
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lw_x0", C_NONE, 1'b0, 32'd1);

    // Load-use on RS2
    set_in(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lw_rs2", C_LW, 1'b0, 32'd1);

    // Taken branch overrides load-use
    set_in(5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("br_lw", C_BR, 1'b0, 32'd2);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle2", C_NONE, 1'b0, 32'd2);

    // MDU sequence with MDU_LAT=4: entry + 3 stalls + release
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mdu_entry", C_MDUE, 1'b0, 32'd2);
    cyc("mdu_c3", C_MDUS, 1'b1, 32'd3);
    cyc("mdu_c2", C_MDUS, 1'b1, 32'd4);
    cyc("mdu_c1", C_MDUS, 1'b1, 32'd5);
    cyc("mdu_rel", C_NONE, 1'b1, 32'd6);

    // Back-to-back op, with a 3-cycle memory wait mid-sequence
    cyc("b2b_entry", C_MDUE, 1'b0, 32'd6);
    cyc("b2b_c3", C_MDUS, 1'b1, 32'd7);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("mw_1", C_MW, 1'b1, 32'd8);
    cyc("mw_2", C_MW, 1'b1, 32'd9);
    cyc("mw_3", C_MW, 1'b1, 32'd10);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("b2b_c2", C_MDUS, 1'b1, 32'd11);
    cyc("b2b_c1", C_MDUS, 1'b1, 32'd12);
    cyc("b2b_rel", C_NONE, 1'b1, 32'd13);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle3", C_NONE, 1'b0, 32'd13);

    // Memory wait on the entry cycle defers MduStart
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("mw_entry", C_MW, 1'b0, 32'd13);
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("late_entry", C_MDUE, 1'b0, 32'd14);
    cyc("late_c3", C_MDUS, 1'b1, 32'd15);

    // Reset while cnt=2: forced low now, clean RUN state next cycle
    rst = 1'b0;
    cyc("rst_mid", C_NONE, 1'b0, 32'd16);
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("post_rst", C_NONE, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
